output_fifo: RTL

OUTPUT_FIFO -- requirements
Module: output_fifo

---
 rtl/nla_pkg.sv | 21 ++
 rtl/output_fifo_if.sv | 27 ++
 rtl/fifo_mem.sv | 22 ++
 rtl/output_fifo.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/nla_pkg.sv
// nla_pkg: constants and FSM state type shared by the result output path.
// Build option: OUTPUT_FIFO_MARKER_EN adds the MARKER state and the NaN
// terminator word appended after each frame.
package nla_pkg;

`ifdef OUTPUT_FIFO_MARKER_EN
    localparam logic [31:0] NLA_NAN_MARKER = 32'h7F90_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        MARKER = 2'd2
    } ofifo_state_e;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1
    } ofifo_state_e;
`endif

endpackage

// File: rtl/output_fifo_if.sv
// output_fifo_if: producer push port plus consumer valid/ready port of the
// result FIFO. slave = the FIFO itself, master = the surrounding logic.
interface output_fifo_if #(
    parameter int RAM_WIDTH = 32
);
    logic                 wr_en;
    logic                 last_i;
    logic [RAM_WIDTH-1:0] data_i;
    logic                 full_o;
    logic                 empty_o;
    logic                 overflow_o;
    logic                 valid_o;
    logic                 ready_i;
    logic [RAM_WIDTH-1:0] data_o;
    logic                 last_o;
    logic                 done_o;

    modport slave (
        input  wr_en, last_i, data_i, ready_i,
        output full_o, empty_o, overflow_o, valid_o, data_o, last_o, done_o
    );

    modport master (
        output wr_en, last_i, data_i, ready_i,
        input  full_o, empty_o, overflow_o, valid_o, data_o, last_o, done_o
    );
endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: buffer storage, one synchronous write port and one
// combinational read port. Contents are deliberately not reset.
module fifo_mem #(
    parameter int WIDTH      = 33,
    parameter int ADDR_LINES = 4
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_LINES-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [ADDR_LINES-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);
    logic [WIDTH-1:0] mem_q [2**ADDR_LINES];

    // Write the pushed word at the write pointer
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/output_fifo.sv
// output_fifo: circular result buffer with a registered output stage and a
// frame FSM that signals done_o once a frame's last word has drained.
// count includes the word currently held in the output register.
// Build option: OUTPUT_FIFO_MARKER_EN appends a NaN terminator beat per frame.
module output_fifo
    import nla_pkg::*;
#(
    parameter int RAM_WIDTH  = 32,
    parameter int ADDR_LINES = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    output_fifo_if.slave bus
);
    localparam logic [ADDR_LINES:0]   CNT_FULL = {1'b1, {ADDR_LINES{1'b0}}};
    localparam logic [ADDR_LINES:0]   CNT_ONE  = (ADDR_LINES+1)'(1);
    localparam logic [ADDR_LINES-1:0] PTR_ONE  = ADDR_LINES'(1);

    logic [ADDR_LINES-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_addr;
    logic [ADDR_LINES:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  out_vld_q, out_vld_d, out_last_q, out_last_d;
    logic [RAM_WIDTH-1:0]  out_data_q, out_data_d;
    logic                  done_q, done_d;
    logic [RAM_WIDTH:0]    rd_word;
    logic                  full, push, pop, out_load, out_avail;
    ofifo_state_e          state_q, state_d;

    assign full           = (count_q == CNT_FULL);
    assign push           = bus.wr_en && !full;
    assign bus.full_o     = full;
    assign bus.empty_o    = (count_q == '0);
    assign bus.overflow_o = ovf_q;
    assign bus.done_o     = done_q;

    fifo_mem #(.WIDTH(RAM_WIDTH + 1), .ADDR_LINES(ADDR_LINES)) u_mem (
        .clk_i   (clk_i),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i ({bus.last_i, bus.data_i}),
        .raddr_i (rd_addr),
        .rdata_o (rd_word)
    );

    // Pointer, occupancy and sticky overflow bookkeeping
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        ovf_d    = ovf_q | (bus.wr_en & full);
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Output register refills when empty or popped; on a pop it fetches the
    // word behind the one leaving, which must already be in storage
    always_comb begin
        rd_addr    = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        out_load   = !out_vld_q || pop;
        out_avail  = pop ? (count_q > CNT_ONE) : (count_q != '0);
        out_vld_d  = out_load ? out_avail : out_vld_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        if (out_load && out_avail) begin
            out_data_d = rd_word[RAM_WIDTH-1:0];
            out_last_d = rd_word[RAM_WIDTH];
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            done_q     <= done_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: a frame ends on its last pop or when the buffer runs dry
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (count_q != '0) state_d = STREAM;
            STREAM: begin
                if (pop && out_last_q)
`ifdef OUTPUT_FIFO_MARKER_EN
                    state_d = MARKER;
`else
                    state_d = IDLE;
`endif
                else if (count_q == '0)
                    state_d = IDLE;
            end
`ifdef OUTPUT_FIFO_MARKER_EN
            MARKER: if (bus.ready_i) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: consumer port drive, pop strobe and done pulse request
    always_comb begin
        bus.valid_o = 1'b0;
        bus.data_o  = out_data_q;
`ifdef OUTPUT_FIFO_MARKER_EN
        bus.last_o  = 1'b0;
`else
        bus.last_o  = out_last_q;
`endif
        done_d      = 1'b0;
        case (state_q)
            STREAM: begin
                bus.valid_o = out_vld_q;
`ifndef OUTPUT_FIFO_MARKER_EN
                done_d      = out_vld_q && bus.ready_i && out_last_q;
`endif
            end
`ifdef OUTPUT_FIFO_MARKER_EN
            MARKER: begin
                bus.valid_o = 1'b1;
                bus.data_o  = RAM_WIDTH'(NLA_NAN_MARKER);
                bus.last_o  = 1'b1;
                done_d      = bus.ready_i;
            end
`endif
            default: bus.valid_o = 1'b0;
        endcase
        pop = (state_q == STREAM) && out_vld_q && bus.ready_i;
    end
endmodule
